// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution unit: turns latched ALU flags into a taken decision,
// issues a one-cycle fetch redirect and sequences the front-end flush.
module branch_resolve_unit #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_branch,
    input  logic                 is_jal,
    input  logic                 is_jalr,
    input  logic [2:0]           funct3,
    input  logic [3:0]           flags,
    input  logic [WIDTH-1:0]     pc,
    input  logic [WIDTH-1:0]     imm,
    input  logic [WIDTH-1:0]     alu_result,
    output logic                 resolved_valid,
    output logic                 resolved_taken,
    output logic                 redirect_valid,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic                 flush,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] taken_count,
    output logic [1:0]           state_dbg
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE and in_valid is ignored everywhere else.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t state, state_next;

    logic [2:0]           funct3_q;
    logic [3:0]           flags_q;
    logic [WIDTH-1:0]     pc_q;
    logic [WIDTH-1:0]     imm_q;
    logic [WIDTH-1:0]     alu_q;
    logic                 branch_q;
    logic                 jal_q;
    logic                 jalr_q;
    logic [3:0]           flush_cnt;
    logic [WIDTH-1:0]     redirect_hold;
    logic [CNT_WIDTH-1:0] count_q;

    logic                 accept;
    logic                 cond_taken;
    logic                 bad_funct3;
    logic                 is_jump;
    logic                 take;
    logic                 illegal_cond;
    logic [WIDTH-1:0]     target;

    assign accept = (state == IDLE) && in_valid;

    // flags_q = {v, c, n, z}
    always_comb begin
        cond_taken = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3_q)
            3'b000:  cond_taken = flags_q[0];
            3'b001:  cond_taken = ~flags_q[0];
            3'b100:  cond_taken = flags_q[1] ^ flags_q[3];
            3'b101:  cond_taken = ~(flags_q[1] ^ flags_q[3]);
            3'b110:  cond_taken = ~flags_q[2];
            3'b111:  cond_taken = flags_q[2];
            default: bad_funct3 = 1'b1;
        endcase
    end

    // jalr > jal > branch: a jump overrides any branch condition or funct3.
    assign is_jump      = jalr_q | jal_q;
    assign take         = is_jump | (branch_q & cond_taken);
    assign illegal_cond = ~is_jump & branch_q & bad_funct3;
    assign target       = jalr_q ? {alu_q[WIDTH-1:1], 1'b0} : pc_q + imm_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RESOLVE;
            RESOLVE: state_next = take ? FLUSH : IDLE;
            FLUSH:   if (flush_cnt == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            funct3_q <= '0;
            flags_q  <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            branch_q <= 1'b0;
            jal_q    <= 1'b0;
            jalr_q   <= 1'b0;
        end else if (accept) begin
            funct3_q <= funct3;
            flags_q  <= flags;
            pc_q     <= pc;
            imm_q    <= imm;
            alu_q    <= alu_result;
            branch_q <= is_branch;
            jal_q    <= is_jal;
            jalr_q   <= is_jalr;
        end
    end

    // Loaded with FLUSH_CYCLES-1 so FLUSH lasts FLUSH_CYCLES cycles in total.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt <= '0;
        end else if (state == RESOLVE && take) begin
            flush_cnt <= FLUSH_LAST;
        end else if (state == FLUSH && flush_cnt != 4'd0) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_hold <= '0;
            count_q       <= '0;
        end else if (state == RESOLVE && take) begin
            redirect_hold <= target;
            if (count_q != {CNT_WIDTH{1'b1}}) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Moore outputs decoded purely from state and latched request data.
    assign in_ready       = (state == IDLE);
    assign resolved_valid = (state == RESOLVE);
    assign resolved_taken = resolved_valid & take;
    assign redirect_valid = resolved_valid & take;
    assign illegal        = resolved_valid & illegal_cond;
    assign flush          = (state == FLUSH);
    assign redirect_pc    = redirect_valid ? target : redirect_hold;
    assign taken_count    = count_q;
    assign state_dbg      = state;

    a_redirect_is_taken: assert property (@(posedge clk) disable iff (!reset_n)
        redirect_valid |-> resolved_taken);
    a_no_ready_in_flush: assert property (@(posedge clk) disable iff (!reset_n)
        flush |-> !in_ready);
    a_illegal_not_taken: assert property (@(posedge clk) disable iff (!reset_n)
        illegal |-> !resolved_taken);

endmodule
